serial_subtractor: RTL
======================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, 4, operand width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  operands and borrow_in are valid this cycle.
REQ-005 in_ready  output  1  block can accept operands this cycle.
REQ-006 a  input  WIDTH  minuend.
REQ-007 b  input  WIDTH  subtrahend.
REQ-008 borrow_in  input  1  incoming borrow, LSB stage.
REQ-009 out_valid  output  1  diff/borrow_out are valid.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 diff  output  WIDTH  a - b - borrow_in, modulo 2^WIDTH.
REQ-012 borrow_out  output  1  borrow out of the MSB stage (1 when a < b + borrow_in, unsigned).

Function
REQ-013 FSM SHALL have states IDLE, SHIFT, DONE; reset state IDLE.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 IDLE: when in_valid && in_ready, latch a, b, borrow_in into shift/borrow registers, clear the bit counter, and go to SHIFT.
REQ-016 SHIFT: one bit per cycle, LSB first; each cycle the bit cell computes d = a_i ^ b_i ^ br and br' = (~a_i & b_i) | (~(a_i ^ b_i) & br); d shifts into diff from the MSB end, and br' is registered.
REQ-017 SHIFT SHALL last exactly WIDTH cycles; on the cycle the counter reaches WIDTH-1, go to DONE with the final br' registered as borrow_out.
REQ-018 Latency: out_valid SHALL rise exactly WIDTH+1 rising edges after the accepting edge.
REQ-019 DONE: diff and borrow_out SHALL hold stable while out_valid && !out_ready; on out_valid && out_ready, go to IDLE (in_ready rises the next cycle; no same-cycle re-accept).
REQ-020 in_valid, a, b, borrow_in SHALL be ignored outside IDLE.
REQ-021 Wrap-around: results SHALL be modulo 2^WIDTH with borrow_out set (e.g. 0 - 1 gives all-ones, borrow_out 1).
REQ-022 diff and borrow_out SHALL be 0 from reset until the first result; they MAY show partial values during SHIFT, but consumers sample them only under out_valid.

Reset
REQ-023 rst_n low SHALL, at any time and in any state including mid-SHIFT, force IDLE, in_ready 1 (once rst_n is high), out_valid 0, diff 0, borrow_out 0, counter 0, overflow 0; an in-flight operation is discarded.
REQ-024 Deassertion SHALL be synchronised externally; the first accept is possible on the first edge with rst_n high.

Configuration
REQ-025 Macro SERIAL_SUBTRACTOR_OVERFLOW_EN: when defined, add output port overflow (1 bit) = two's-complement signed overflow of a - b - borrow_in (a_msb != b_msb && diff_msb != a_msb), valid and held with out_valid, reset 0; when undefined, the port and its logic are absent.

Structure
REQ-026 The shared package SHALL hold the FSM state typedef (IDLE/SHIFT/DONE) and the WIDTH legal-range constants.
REQ-027 The per-bit cell SHALL be a sub-module full_subtractor (a, b, borrow_in -> diff, borrow_out; combinational); all registers live in serial_subtractor.

Verification (WIDTH=4)
REQ-028 a=9, b=3, borrow_in=0 -> out_valid 5 edges after accept, diff=6, borrow_out=0.
REQ-029 a=0, b=1, borrow_in=0 -> diff=15, borrow_out=1.
REQ-030 a=5, b=5, borrow_in=1 -> diff=15, borrow_out=1; a=5, b=5, borrow_in=0 -> diff=0, borrow_out=0.
REQ-031 Backpressure: out_ready low for 3 cycles in DONE -> diff, borrow_out and out_valid stable; in_ready stays 0 and in_valid pulses are ignored; out_ready high -> IDLE next edge.
REQ-032 Reset pulse on the 2nd SHIFT cycle of a=9, b=3 -> all outputs 0, in_ready 1; a new a=7, b=2 transaction then yields diff=5, borrow_out=0.
REQ-033 With SERIAL_SUBTRACTOR_OVERFLOW_EN: a=8 (-8), b=1, borrow_in=0 -> diff=7, overflow=1, borrow_out=0; a=3, b=1 -> overflow=0.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Build option: SERIAL_SUBTRACTOR_OVERFLOW_EN adds the signed overflow output.
package serial_subtractor_pkg;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t SHIFT = 2'd1;
    localparam state_t DONE  = 2'd2;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit combinational full subtractor used as the serial bit cell.
// Computes a - b - borrow_in for a single bit position.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic borrow_in,
    output logic diff,
    output logic borrow_out
);

    logic w_x;

    assign w_x        = a ^ b;
    assign diff       = w_x ^ borrow_in;
    assign borrow_out = (~a & b) | (~w_x & borrow_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: LSB first, one bit per clock, valid/ready on both sides.
// Build option: SERIAL_SUBTRACTOR_OVERFLOW_EN adds port overflow.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    output logic             borrow_out,
    output logic             overflow
`else
    output logic             borrow_out
`endif
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    generate
        if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
            $error("serial_subtractor: WIDTH out of range");
        end
    endgenerate

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic [CNT_W-1:0] r_cnt;
    logic             r_br;
    logic             r_bout;
    logic             w_d;
    logic             w_br;

    full_subtractor u_cell (
        .a          (r_a[0]),
        .b          (r_b[0]),
        .borrow_in  (r_br),
        .diff       (w_d),
        .borrow_out (w_br)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_diff  <= '0;
            r_cnt   <= '0;
            r_br    <= 1'b0;
            r_bout  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_br    <= borrow_in;
                        r_cnt   <= '0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_a    <= r_a >> 1;
                    r_b    <= r_b >> 1;
                    r_diff <= {w_d, r_diff[WIDTH-1:1]};
                    r_br   <= w_br;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_bout  <= w_br;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    // Operand sign bits are shifted out, so keep copies for the final check.
    logic r_a_msb;
    logic r_b_msb;
    logic r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (r_state == IDLE && in_valid) begin
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
        end else if (r_state == SHIFT && r_cnt == LAST) begin
            r_ovf <= (r_a_msb ^ r_b_msb) & (w_d ^ r_a_msb);
        end
    end

    assign overflow = r_ovf;
`endif

    assign in_ready   = (r_state == IDLE);
    assign out_valid  = (r_state == DONE);
    assign diff       = r_diff;
    assign borrow_out = r_bout;

endmodule
